pipe_stage_reg_hs: RTL and testbench
====================================

// Module: pipe_stage_reg_hs
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, flush and optional skid buffer.
//  Replaces the fixed per-stage registers (ID/EX, EX/MEM, MEM/WB) with one reusable block.
//  Control bits (write enables, mem enables) and data bits are separated so a flushed or empty slot emits a safe bubble.
//  Includes a saturating stall counter for performance analysis.
// PARAMETERS
//  DATA_W     32   width of data payload (operands, ALU result, addresses), not cleared on bubble
//  CTRL_W     8    width of control payload; forced to CTRL_BUB whenever out_valid_o=0
//  CTRL_BUB   0    CTRL_W-bit bubble/reset value of control payload
//  SKID       1    0: single register, in_ready_o combinational; 1: 2-entry skid, in_ready_o registered
//  CNT_W      16   width of stall counter
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_n_i        in   1       async active-low reset
//  flush_i        in   1       discard all held entries this cycle (branch/exception)
//  in_valid_i     in   1       upstream beat valid
//  in_ready_o     out  1       stage accepts beat this cycle
//  in_data_i      in   DATA_W  upstream data payload
//  in_ctrl_i      in   CTRL_W  upstream control payload
//  out_valid_o    out  1       downstream beat valid
//  out_ready_i    in   1       downstream accepts beat
//  out_data_o     out  DATA_W  data of head entry
//  out_ctrl_o     out  CTRL_W  control of head entry; CTRL_BUB when out_valid_o=0
//  stall_cnt_o    out  CNT_W   cycles with out_valid_o=1 and out_ready_i=0, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid_o=0, out_data_o=0, out_ctrl_o=CTRL_BUB, stall_cnt_o=0,
//    skid empty; in_ready_o=1 from first cycle after release. Reset mid-transfer drops all entries.
//  - Handshake: beat transfers when valid&ready at rising edge; valid never depends on ready;
//    payload held stable while out_valid_o=1 and out_ready_i=0. Latency in->out: 1 cycle.
//  - SKID=0: in_ready_o = !out_valid_o | out_ready_i (combinational). Single register.
//  - SKID=1: states EMPTY(0 held), MAIN(1 held), SKID(2 held). in_ready_o=1 in EMPTY/MAIN, 0 in SKID (registered).
//    EMPTY: in_valid -> MAIN. MAIN: in&out -> MAIN (replace); in&!out -> SKID (beat into skid);
//    !in&out -> EMPTY. SKID: out_ready_i -> MAIN (skid moves to main, same cycle).
//    Throughput 1 beat/cycle sustained; order strictly preserved.
//  - Flush: next state EMPTY, out_valid_o=0 next cycle. An input beat handshaken in the flush cycle is
//    dropped (handshake completes, beat discarded). Flush overrides simultaneous in/out transfers.
//  - Bubble: out_ctrl_o=CTRL_BUB whenever out_valid_o=0; out_data_o keeps last value (don't-care).
//  - stall_cnt_o: +1 per cycle with out_valid_o&!out_ready_i; saturates at 2^CNT_W-1; cleared only by reset.
//  - out_ready_i ignored when out_valid_o=0; in_data_i/in_ctrl_i ignored when in_valid_i=0.
// STRUCTURE
//  - Package pipe_pkg: state enum encoding {EMPTY, MAIN, SKID}, default CTRL_BUB constant,
//    ctrl field bit positions (dmem_ena, dmem_wena, dmem_type[1:0], rd_sel, rd_wena).
//  - Sub-module pipe_slot: one {valid,data,ctrl} register with load/clear; instantiated once (SKID=0) or twice.
//  - Top holds FSM, ready logic, bubble mux, stall counter; generate on SKID.
// TESTING
//  1 Reset: hold rst_n_i=0 with in_valid_i=1 -> out_valid_o=0, out_ctrl_o=CTRL_BUB, stall_cnt_o=0, in_ready_o=1 after release.
//  2 Streaming SKID=1: 10 beats data=1..10, out_ready_i=1 -> 10 beats out in order, 1-cycle latency, no gaps.
//  3 Backpressure SKID=1: out_ready_i=0 for 4 cycles during stream -> skid fills, in_ready_o=0 next cycle,
//    no beat lost/duplicated, stall_cnt_o=4.
//  4 Flush in SKID state with in_valid_i=1 -> next cycle out_valid_o=0, out_ctrl_o=CTRL_BUB, both held beats
//    and incoming beat dropped; next beat passes normally.
//  5 SKID=0: out_ready_i toggles 1/0 each cycle -> in_ready_o tracks combinationally, data order intact.
//  6 Saturation CNT_W=4: out_ready_i=0 for 20 cycles with out_valid_o=1 -> stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared types and constants for the handshaked pipeline stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Occupancy of the skid-buffered stage: number of beats currently held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Default bubble value for the control payload (all enables off).
  localparam logic [7:0] c_CTRL_BUB_DEFAULT = 8'h00;

  // Bit positions of the standard control fields carried in the ctrl payload.
  localparam int c_CTRL_DMEM_ENA    = 0;
  localparam int c_CTRL_DMEM_WENA   = 1;
  localparam int c_CTRL_DMEM_TYPE_LO = 2;
  localparam int c_CTRL_DMEM_TYPE_HI = 3;
  localparam int c_CTRL_RD_SEL      = 4;
  localparam int c_CTRL_RD_WENA     = 5;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module  : pipe_slot
// Brief   : One {valid, data, ctrl} holding register with load and clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUB = CTRL_W'(c_CTRL_BUB_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Load wins over clear; clearing only drops valid so data keeps its last value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_BUB;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg_hs.sv
// ============================================================================
// Module  : pipe_stage_reg_hs
// Brief   : Reusable pipeline stage register with valid/ready handshake,
//           flush, optional 2-entry skid buffer and saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg_hs
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUB = CTRL_W'(c_CTRL_BUB_DEFAULT),
  parameter int                 SKID     = 1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Head entry (the one presented downstream)
  logic              w_head_valid;
  logic [DATA_W-1:0] w_head_data;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [CNT_W-1:0]  stall_cnt_q;

  generate
    if (SKID == 0) begin : g_single
      logic w_load;
      logic w_clear;

      assign in_ready_o = !w_head_valid || out_ready_i;
      // A beat accepted during flush completes its handshake but is discarded.
      assign w_load  = in_valid_i && in_ready_o && !flush_i;
      assign w_clear = flush_i || out_ready_i;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUB(CTRL_BUB)) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_load),
        .clear_i (w_clear),
        .data_i  (in_data_i),
        .ctrl_i  (in_ctrl_i),
        .valid_o (w_head_valid),
        .data_o  (w_head_data),
        .ctrl_o  (w_head_ctrl)
      );
    end else begin : g_skid
      state_e            state_q;
      state_e            state_d;
      logic              w_load_main;
      logic              w_load_skid;
      logic              w_move;
      logic              w_clr_main;
      logic              w_clr_skid;
      logic              w_skid_valid;
      logic [DATA_W-1:0] w_skid_data;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [DATA_W-1:0] w_main_data;
      logic [CTRL_W-1:0] w_main_ctrl;

      // The skid slot is occupied exactly in ST_SKID, so its valid bit is a
      // registered "full" flag and gives a glitch-free in_ready_o.
      assign in_ready_o = !w_skid_valid;

      // Occupancy state register
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_EMPTY;
        else          state_q <= state_d;
      end

      // Next occupancy and slot load/clear/move controls; flush overrides all
      always_comb begin
        state_d     = state_q;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move      = 1'b0;
        w_clr_main  = 1'b0;
        w_clr_skid  = 1'b0;
        if (flush_i) begin
          state_d    = ST_EMPTY;
          w_clr_main = 1'b1;
          w_clr_skid = 1'b1;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_valid_i) begin
                w_load_main = 1'b1;
                state_d     = ST_MAIN;
              end
            end
            ST_MAIN: begin
              if (in_valid_i && out_ready_i) begin
                w_load_main = 1'b1;
              end else if (in_valid_i) begin
                w_load_skid = 1'b1;
                state_d     = ST_SKID;
              end else if (out_ready_i) begin
                w_clr_main  = 1'b1;
                state_d     = ST_EMPTY;
              end
            end
            ST_SKID: begin
              if (out_ready_i) begin
                w_move     = 1'b1;
                w_clr_skid = 1'b1;
                state_d    = ST_MAIN;
              end
            end
            default: begin
              state_d    = ST_EMPTY;
              w_clr_main = 1'b1;
              w_clr_skid = 1'b1;
            end
          endcase
        end
      end

      assign w_main_data = w_move ? w_skid_data : in_data_i;
      assign w_main_ctrl = w_move ? w_skid_ctrl : in_ctrl_i;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUB(CTRL_BUB)) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_load_main || w_move),
        .clear_i (w_clr_main),
        .data_i  (w_main_data),
        .ctrl_i  (w_main_ctrl),
        .valid_o (w_head_valid),
        .data_o  (w_head_data),
        .ctrl_o  (w_head_ctrl)
      );

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUB(CTRL_BUB)) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_load_skid),
        .clear_i (w_clr_skid),
        .data_i  (in_data_i),
        .ctrl_i  (in_ctrl_i),
        .valid_o (w_skid_valid),
        .data_o  (w_skid_data),
        .ctrl_o  (w_skid_ctrl)
      );
    end
  endgenerate

  // Saturating count of cycles where a valid head is held back downstream
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (w_head_valid && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid_o = w_head_valid;
  assign out_data_o  = w_head_data;
  assign out_ctrl_o  = w_head_valid ? w_head_ctrl : CTRL_BUB;
  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg_hs.sv
// ============================================================================
// Module  : tb_pipe_stage_reg_hs
// Brief   : Self-checking bench for pipe_stage_reg_hs (skid, single, sat).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg_hs;

  localparam logic [7:0] BUB_A = 8'h5A;
  localparam logic [7:0] BUB_B = 8'h00;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } beat_t;

  typedef struct packed {
    logic iv;
    logic ordy;
    logic rdy;
    logic vld;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [7:0]  a_out_ctrl;
  logic [15:0] a_stall;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [7:0]  b_out_ctrl;
  logic [15:0] b_stall;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [7:0]  c_out_ctrl;
  logic [3:0]  c_stall;

  logic        sel;   // 0: skid instance A, 1: single-register instance B
  logic        act_rdy, act_vld;
  logic [31:0] act_data;
  logic [7:0]  act_ctrl, act_bub;
  logic [15:0] act_stall;

  assign act_rdy   = sel ? b_in_ready  : a_in_ready;
  assign act_vld   = sel ? b_out_valid : a_out_valid;
  assign act_data  = sel ? b_out_data  : a_out_data;
  assign act_ctrl  = sel ? b_out_ctrl  : a_out_ctrl;
  assign act_stall = sel ? b_stall     : a_stall;
  assign act_bub   = sel ? BUB_B       : BUB_A;

  always #5 clk = ~clk;

  pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .CTRL_BUB(BUB_A), .SKID(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .out_ctrl_o(a_out_ctrl), .stall_cnt_o(a_stall));

  pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .CTRL_BUB(BUB_B), .SKID(0), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .out_ctrl_o(b_out_ctrl), .stall_cnt_o(b_stall));

  pipe_stage_reg_hs #(.DATA_W(32), .CTRL_W(8), .CTRL_BUB(BUB_A), .SKID(1), .CNT_W(4)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(c_in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(c_out_valid), .out_ready_i(out_ready), .out_data_o(c_out_data),
    .out_ctrl_o(c_out_ctrl), .stall_cnt_o(c_stall));

  int          n_vec = 0;
  int          n_bad = 0;
  int          rx;
  logic [31:0] seq;
  logic [15:0] exp_stall;
  logic [3:0]  exp_stall_c;
  beat_t       q[$];
  logic        tab_en;
  logic        tab_rdy, tab_vld;
  vec_t        tab[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctrl_of(input logic [31:0] x);
    return x[7:0] ^ 8'hC3;
  endfunction

  // One clock cycle: sample mid-cycle, compare against the FIFO model,
  // update the model with the handshakes that occur at the next edge.
  task automatic cyc();
    logic  exp_vld, exp_rdy, hs_in, hs_out;
    beat_t e;
    #4;
    exp_vld = (q.size() > 0);
    exp_rdy = sel ? ((q.size() == 0) || out_ready) : (q.size() < 2);
    chk("in_ready", act_rdy, exp_rdy);
    chk("out_valid", act_vld, exp_vld);
    if (exp_vld) begin
      chk("out_data", act_data, q[0].d);
      chk("out_ctrl", act_ctrl, q[0].c);
    end else begin
      chk("bubble_ctrl", act_ctrl, act_bub);
    end
    chk("stall_cnt", act_stall, exp_stall);
    if (!sel) chk("stall_cnt_c", c_stall, exp_stall_c);
    if (tab_en) begin
      chk("tab_in_ready", act_rdy, tab_rdy);
      chk("tab_out_valid", act_vld, tab_vld);
    end
    hs_in  = in_valid && exp_rdy;
    hs_out = exp_vld && out_ready;
    if (hs_out) begin
      void'(q.pop_front());
      rx++;
    end
    if (flush) begin
      q.delete();
    end else if (hs_in) begin
      e.d = in_data;
      e.c = in_ctrl;
      q.push_back(e);
    end
    if (hs_in) seq++;
    if (exp_vld && !out_ready) begin
      if (exp_stall != 16'hFFFF) exp_stall++;
      if (exp_stall_c != 4'hF)   exp_stall_c++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = seq;
    in_ctrl   = ctrl_of(seq);
    cyc();
  endtask

  // Assert reset (with traffic on the inputs), check the reset state, release.
  task automatic do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b0;
    in_data   = 32'hFFFF_FFFF;
    in_ctrl   = 8'hFF;
    rst_n     = 1'b0;
    #2;
    chk("rst_out_valid", act_vld, 1'b0);
    chk("rst_out_ctrl", act_ctrl, act_bub);
    chk("rst_stall", act_stall, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    exp_stall   = '0;
    exp_stall_c = '0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
  endtask

  initial begin
    tab[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tab[2]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tab[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tab[6]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tab[10] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tab[11] = '{1'b0, 1'b0, 1'b1, 1'b0};

    sel     = 1'b0;
    tab_en  = 1'b0;
    tab_rdy = 1'b0;
    tab_vld = 1'b0;
    seq     = 32'd1;
    rx      = 0;
    @(posedge clk);
    #1;

    // Reset with in_valid held high
    do_reset();
    drive(1'b0, 1'b1, 1'b0);

    // Streaming: beats 1..10, no backpressure
    rx = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("stream_count", rx, 10);

    // Backpressure for 4 cycles mid-stream
    for (int i = 0; i < 12; i++) drive(1'b1, !(i >= 2 && i < 6), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
    chk("bp_stall", a_stall, 16'd4);

    // Flush while both slots are full and a new beat is offered
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("skid_full_ready", a_in_ready, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ctrl", a_out_ctrl, BUB_A);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    // Flush with one held beat while a new beat is handshaken
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    // Saturation of the 4-bit counter: 20 stalled cycles
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0);
    chk("sat_c", c_stall, 4'd15);

    // Reset while a beat is held, then the single-register variant
    do_reset();
    sel = 1'b1;
    #1;
    chk("rst_b_valid", b_out_valid, 1'b0);
    chk("rst_b_stall", b_stall, 16'd0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    exp_stall = '0;

    tab_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tab_rdy = tab[i].rdy;
      tab_vld = tab[i].vld;
      drive(tab[i].iv, tab[i].ordy, 1'b0);
    end
    tab_en = 1'b0;
    chk("b_stall", b_stall, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
